// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter.
//   WB_DATA_W / WB_ADDR_W : default register data and address widths
//   wb_entry_t            : one buffered EXU result {addr, data, ret}
//   wb_state_t            : source of the most recent grant
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
      logic                 ret;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      EXU  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t used to buffer EXU results.
// Ports:
//   clk_sys      in   clock, rising edge
//   rst          in   synchronous reset, active-high (drops all entries)
//   push         in   write push_entry when not full
//   push_entry   in   entry to store
//   pop          in   drop the head entry when not empty
//   head         out  oldest entry (meaningful only when !empty)
//   full         out  DEPTH entries held
//   empty        out  no entries held
// A push while full is refused even if a pop happens in the same cycle.
// There is no bypass: a pushed entry becomes the head one cycle later at the earliest.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic      clk_sys,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (cnt_q == CNT_FULL);
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_sys) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the single register-file write port between the execute unit (EXU)
// and the memory unit (MEM). EXU results are buffered in a small FIFO; each
// cycle at most one source is granted and the write port is driven from
// registers one cycle after the grant.
// Ports:
//   iClk, iRst                       clock, synchronous active-high reset
//   iExuValid/oExuReady              EXU handshake, iExuData/iExuAddr/iRetCmd payload
//   iMemValid/oMemReady              MEM handshake, iMemData/iMemAddr payload
//   oRegWrite/oWriteAddr/oWriteData  registered register-file write port
//   oBusy                            FIFO non-empty or a write in flight
// Build option:
//   WB_ARB_STARVE_GUARD_EN  when defined, after MAX_WAIT consecutive MEM grants
//                           with EXU results pending, MEM is held off for one
//                           cycle and the FIFO head is granted instead.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no grant last cycle
// MEM   | load data granted last cycle (write in flight)
// EXU   | FIFO head granted last cycle (write in flight)
module writeback_arbiter
   import wb_pkg::*;
#(
   // DATA_W/ADDR_W must match the wb_pkg widths used by wb_entry_t.
   parameter int DATA_W     = WB_DATA_W,
   parameter int ADDR_W     = WB_ADDR_W,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 4
)(
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iExuValid,
   output logic              oExuReady,
   input  logic [DATA_W-1:0] iExuData,
   input  logic [ADDR_W-1:0] iExuAddr,
   input  logic              iRetCmd,
   input  logic              iMemValid,
   output logic              oMemReady,
   input  logic [DATA_W-1:0] iMemData,
   input  logic [ADDR_W-1:0] iMemAddr,
   output logic              oRegWrite,
   output logic [ADDR_W-1:0] oWriteAddr,
   output logic [DATA_W-1:0] oWriteData,
   output logic              oBusy
);

   localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

   wb_entry_t         push_entry;
   wb_entry_t         fifo_head;
   logic              fifo_full;
   logic              fifo_empty;

   wb_state_t         state_q, state_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   logic              force_exu;
   logic              grant_mem;
   logic              grant_exu;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic [DATA_W-1:0] ret_data;

   always_comb begin
      push_entry      = '0;
      push_entry.addr = iExuAddr;
      push_entry.data = iExuData;
      push_entry.ret  = iRetCmd;
   end

   wb_fifo #(
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys    (iClk),
      .rst        (iRst),
      .push       (iExuValid),
      .push_entry (push_entry),
      .pop        (grant_exu),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

`ifdef WB_ARB_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   assign force_exu = (wait_cnt_q == WAIT_LIMIT) && !fifo_empty;

   // Counts MEM grants that overtook a pending EXU result; the force above
   // blocks further MEM grants at the limit, so the count cannot overflow.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (fifo_empty || grant_exu) begin
         wait_cnt_d = '0;
      end else if (grant_mem) begin
         wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) wait_cnt_q <= '0;
      else      wait_cnt_q <= wait_cnt_d;
   end
`else
   assign force_exu = 1'b0;
`endif

   assign ret_data = fifo_head.data + DATA_ONE;

   always_comb begin
      grant_mem = iMemValid && !force_exu;
      grant_exu = !grant_mem && !fifo_empty;

      win_addr  = fifo_head.addr;
      win_data  = fifo_head.ret ? ret_data : fifo_head.data;
      if (grant_mem) begin
         win_addr = iMemAddr;
         win_data = iMemData;
      end

      state_d      = IDLE;
      reg_write_d  = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      if (grant_mem || grant_exu) begin
         state_d      = grant_mem ? MEM : EXU;
         // Writes to r0 complete the handshake but never reach the register file.
         reg_write_d  = (win_addr != '0);
         write_addr_d = win_addr;
         write_data_d = win_data;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q      <= IDLE;
         reg_write_q  <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         reg_write_q  <= reg_write_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
      end
   end

   assign oExuReady  = !fifo_full;
   assign oMemReady  = !force_exu;
   assign oRegWrite  = reg_write_q;
   assign oWriteAddr = write_addr_q;
   assign oWriteData = write_data_q;
   // A non-IDLE state means last cycle's grant is on the write port now.
   assign oBusy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          iClk = 1'b0;
   logic          iRst;
   logic          iExuValid;
   logic          oExuReady;
   logic [DW-1:0] iExuData;
   logic [AW-1:0] iExuAddr;
   logic          iRetCmd;
   logic          iMemValid;
   logic          oMemReady;
   logic [DW-1:0] iMemData;
   logic [AW-1:0] iMemAddr;
   logic          oRegWrite;
   logic [AW-1:0] oWriteAddr;
   logic [DW-1:0] oWriteData;
   logic          oBusy;

   writeback_arbiter dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iExuValid  (iExuValid),
      .oExuReady  (oExuReady),
      .iExuData   (iExuData),
      .iExuAddr   (iExuAddr),
      .iRetCmd    (iRetCmd),
      .iMemValid  (iMemValid),
      .oMemReady  (oMemReady),
      .iMemData   (iMemData),
      .iMemAddr   (iMemAddr),
      .oRegWrite  (oRegWrite),
      .oWriteAddr (oWriteAddr),
      .oWriteData (oWriteData),
      .oBusy      (oBusy)
   );

   always #5 iClk = ~iClk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   // MEM traffic uses addresses 16..30, EXU traffic 1..15 and 31, so each
   // observed write can be routed to its own in-order expectation queue.
   wr_t exp_mem[$];
   wr_t exp_exu[$];
   int  exu_pos[$];
   int  wr_count = 0;
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  mem_acc;
   bit  exu_acc;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: record handshakes (and expected writes) before the edge,
   // return 1 time unit after the edge with registered outputs settled.
   task automatic tick();
      @(negedge iClk);
      mem_acc = !iRst && iMemValid && oMemReady;
      exu_acc = !iRst && iExuValid && oExuReady;
      if (mem_acc && iMemAddr != '0) exp_mem.push_back({iMemAddr, iMemData});
      if (exu_acc && iExuAddr != '0)
         exp_exu.push_back({iExuAddr, iRetCmd ? iExuData + 32'd1 : iExuData});
      @(posedge iClk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((oBusy !== 1'b0 || exp_mem.size() != 0 || exp_exu.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, DW'(exp_mem.size() + exp_exu.size()), 32'd0);
      chk({tag, "_busy"}, oBusy, 1'b0);
   endtask

   always @(negedge iClk) begin
      wr_t e;
      if (oRegWrite === 1'b1) begin
         wr_count++;
         if (oWriteAddr >= AW'(16) && oWriteAddr <= AW'(30)) begin
            if (exp_mem.size() == 0) begin
               chk("unexpected_mem_write", oRegWrite, 1'b0);
            end else begin
               e = exp_mem.pop_front();
               chk("mem_write_addr", oWriteAddr, e.addr);
               chk("mem_write_data", oWriteData, e.data);
            end
         end else begin
            if (exp_exu.size() == 0) begin
               chk("unexpected_exu_write", oRegWrite, 1'b0);
            end else begin
               e = exp_exu.pop_front();
               exu_pos.push_back(wr_count);
               chk("exu_write_addr", oWriteAddr, e.addr);
               chk("exu_write_data", oWriteData, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mem_sent;
      int exu_sent;
      int stalls;

      iRst = 1'b1;
      iExuValid = 1'b0; iExuData = '0; iExuAddr = '0; iRetCmd = 1'b0;
      iMemValid = 1'b0; iMemData = '0; iMemAddr = '0;
      tick();
      tick();
      chk("reset_regwrite", oRegWrite, 1'b0);
      chk("reset_addr", oWriteAddr, '0);
      chk("reset_data", oWriteData, '0);
      chk("reset_busy", oBusy, 1'b0);
      chk("reset_exu_ready", oExuReady, 1'b1);
      chk("reset_mem_ready", oMemReady, 1'b1);
      iRst = 1'b0;
      tick();

      // EXU-only result, two cycles from push to write
      iExuValid = 1'b1; iExuAddr = 5'd3; iExuData = 32'h10; iRetCmd = 1'b0;
      tick();
      iExuValid = 1'b0;
      chk("t1_accepted", exu_acc, 1'b1);
      chk("t1_no_bypass", oRegWrite, 1'b0);
      chk("t1_busy", oBusy, 1'b1);
      tick();
      chk("t1_write", oRegWrite, 1'b1);
      chk("t1_addr", oWriteAddr, 5'd3);
      chk("t1_data", oWriteData, 32'h10);
      tick();
      chk("t1_pulse", oRegWrite, 1'b0);
      chk("t1_idle", oBusy, 1'b0);

      // Return address wraps to zero
      iExuValid = 1'b1; iExuAddr = 5'd31; iExuData = 32'hFFFF_FFFF; iRetCmd = 1'b1;
      tick();
      iExuValid = 1'b0; iRetCmd = 1'b0;
      tick();
      chk("t2_write", oRegWrite, 1'b1);
      chk("t2_addr", oWriteAddr, 5'd31);
      chk("t2_data", oWriteData, 32'h0);
      drain("t2_drain", 10);

      // Contention: MEM valid every cycle, three EXU results
      wr_count = 0;
      exu_pos.delete();
      mem_sent = 0; exu_sent = 0; stalls = 0;
      iMemValid = 1'b1; iMemAddr = 5'd16; iMemData = 32'hA000_0000;
      iExuValid = 1'b1; iExuAddr = 5'd1;  iExuData = 32'hE000_0000; iRetCmd = 1'b0;
      for (int c = 0; c < 60 && mem_sent < 15; c++) begin
         tick();
         if (mem_acc) mem_sent++;
         else stalls++;
         if (exu_acc) begin
            exu_sent++;
            if (exu_sent == 2) chk("t3_full_after_two", oExuReady, 1'b0);
         end
         iMemAddr = AW'(16 + (mem_sent % 15));
         iMemData = 32'hA000_0000 + DW'(mem_sent);
         iExuAddr = AW'(1 + exu_sent);
         iExuData = 32'hE000_0000 + DW'(exu_sent);
         if (exu_sent == 3) iExuValid = 1'b0;
      end
      iMemValid = 1'b0;
      chk("t3_mem_sent", DW'(mem_sent), 32'd15);
`ifdef WB_ARB_STARVE_GUARD_EN
      chk("t3_mem_stalls", DW'(stalls), 32'd3);
      chk("t3_exu_writes_in_burst", DW'(exu_pos.size()), 32'd3);
`else
      chk("t3_mem_stalls", DW'(stalls), 32'd0);
      chk("t3_exu_writes_in_burst", DW'(exu_pos.size()), 32'd0);
`endif
      for (int c = 0; c < 20 && exu_sent < 3; c++) begin
         tick();
         if (exu_acc) exu_sent++;
      end
      iExuValid = 1'b0;
      chk("t3_exu_sent", DW'(exu_sent), 32'd3);
      drain("t3_drain", 40);
      chk("t3_total_writes", DW'(wr_count), 32'd18);
`ifdef WB_ARB_STARVE_GUARD_EN
      chk("t3_exu_pos0", DW'(exu_pos[0]), 32'd6);
      chk("t3_exu_pos1", DW'(exu_pos[1]), 32'd11);
      chk("t3_exu_pos2", DW'(exu_pos[2]), 32'd16);
`else
      chk("t3_exu_pos0", DW'(exu_pos[0]), 32'd16);
      chk("t3_exu_pos1", DW'(exu_pos[1]), 32'd17);
      chk("t3_exu_pos2", DW'(exu_pos[2]), 32'd18);
`endif

      // Address 0: consumed silently
      iExuValid = 1'b1; iExuAddr = 5'd0; iExuData = 32'h55; iRetCmd = 1'b0;
      tick();
      iExuValid = 1'b0;
      chk("t4_accepted", exu_acc, 1'b1);
      tick();
      chk("t4_no_write", oRegWrite, 1'b0);
      chk("t4_addr", oWriteAddr, 5'd0);
      chk("t4_data", oWriteData, 32'h55);
      tick();
      chk("t4_popped", oBusy, 1'b0);
      chk("t4_ready", oExuReady, 1'b1);

      // Full FIFO: push refused in the pop cycle, accepted the next
      iMemValid = 1'b1; iMemAddr = 5'd20; iMemData = 32'hA100_0001;
      iExuValid = 1'b1; iExuAddr = 5'd5;  iExuData = 32'h500;
      tick();
      chk("t5_push_a", exu_acc, 1'b1);
      iMemAddr = 5'd21; iMemData = 32'hA100_0002;
      iExuAddr = 5'd6;  iExuData = 32'h600;
      tick();
      chk("t5_full", oExuReady, 1'b0);
      iMemValid = 1'b0;
      iExuAddr = 5'd7; iExuData = 32'h700;
      tick();
      chk("t5_refused_while_full", exu_acc, 1'b0);
      chk("t5_ready_after_pop", oExuReady, 1'b1);
      tick();
      chk("t5_push_accepted", exu_acc, 1'b1);
      iExuValid = 1'b0;
      drain("t5_drain", 20);

      // Reset with two entries buffered
      iMemValid = 1'b1; iMemAddr = 5'd22; iMemData = 32'hA200_0001;
      iExuValid = 1'b1; iExuAddr = 5'd8;  iExuData = 32'h800;
      tick();
      iMemAddr = 5'd23; iMemData = 32'hA200_0002;
      iExuAddr = 5'd9;  iExuData = 32'h900;
      tick();
      chk("t6_two_buffered", oExuReady, 1'b0);
      iMemValid = 1'b0; iExuValid = 1'b0;
      iRst = 1'b1;
      tick();
      chk("t6_regwrite", oRegWrite, 1'b0);
      chk("t6_addr", oWriteAddr, '0);
      chk("t6_data", oWriteData, '0);
      chk("t6_busy", oBusy, 1'b0);
      chk("t6_exu_ready", oExuReady, 1'b1);
      chk("t6_mem_ready", oMemReady, 1'b1);
      exp_exu.delete();
      iRst = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      chk("t6_pending", DW'(exp_mem.size() + exp_exu.size()), 32'd0);
      chk("t6_still_idle", oBusy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
